// File: rtl/fifo_pkg.sv
// Shared definitions for the async FIFO read and write controllers.
//   bin2gray / gray2bin : pointer code conversion, width passed as an argument so one
//                         definition serves every pointer width up to PtrMaxW bits.
//   out_state_e         : read-side output stage state (IDLE = empty, HOLD = word held).
package fifo_pkg;

    localparam int unsigned PtrMaxW = 32;

    typedef enum logic {
        IDLE,
        HOLD
    } out_state_e;

    // All-ones mask covering the low 'width' bits.
    function automatic logic [PtrMaxW-1:0] width_mask(input int unsigned width);
        if (width >= PtrMaxW) begin
            return '1;
        end
        return (PtrMaxW'(1) << width) - PtrMaxW'(1);
    endfunction

    function automatic logic [PtrMaxW-1:0] bin2gray(input logic [PtrMaxW-1:0] bin,
                                                    input int unsigned        width);
        logic [PtrMaxW-1:0] b;
        b = bin & width_mask(width);
        return b ^ (b >> 1);
    endfunction

    // Each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [PtrMaxW-1:0] gray2bin(input logic [PtrMaxW-1:0] gray,
                                                    input int unsigned        width);
        logic [PtrMaxW-1:0] g;
        logic [PtrMaxW-1:0] b;
        g = gray & width_mask(width);
        b = g;
        for (int unsigned i = 1; i < width; i++) begin
            b = b ^ (g >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of the async FIFO.
// Owns the read pointer, addresses the RAM's combinational read port and presents the
// fetched word on a registered AXI-Stream-style master interface. The read pointer is
// published Gray-coded straight from a flop for synchronisation into the write domain.
//
// Ports:
//   rd_clk           read-domain clock, all logic on its rising edge
//   rd_rst_n         synchronous active-low reset
//   wr_ptr_gray_sync write pointer (Gray), already synchronised into rd_clk
//   rd_ptr_gray      read pointer (Gray), registered
//   ram_rd_addr      RAM read address
//   ram_rd_data      RAM read data, combinational from ram_rd_addr
//   m_tdata          output data, registered
//   m_tvalid         output data valid
//   m_tready         downstream ready
//   ram_empty        no unread words left in the RAM (output register may hold one)
//   rd_count         unread RAM words, registered (only with FIFO_RD_COUNT_EN)
//
// Optional feature macro: FIFO_RD_COUNT_EN adds the rd_count output.
module fifo_rd_ctrl
    import fifo_pkg::*;
#(
    parameter int unsigned DWIDTH = 64,
    parameter int unsigned DEPTH  = 16,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned PW    = AW + 1
) (
    input  logic              rd_clk,
    input  logic              rd_rst_n,
    input  logic [AW:0]       wr_ptr_gray_sync,
    output logic [AW:0]       rd_ptr_gray,
    output logic [AW-1:0]     ram_rd_addr,
    input  logic [DWIDTH-1:0] ram_rd_data,
    output logic [DWIDTH-1:0] m_tdata,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic              ram_empty
`ifdef FIFO_RD_COUNT_EN
    ,
    output logic [AW:0]       rd_count
`endif
);

    out_state_e        state_q, state_d;
    logic [AW:0]       rd_ptr_bin_q, rd_ptr_bin_d;
    logic [AW:0]       rd_ptr_gray_q, rd_ptr_gray_d;
    logic [DWIDTH-1:0] tdata_q, tdata_d;
    logic [AW:0]       wr_ptr_bin;
    logic [AW:0]       rd_ptr_bin_inc;
    logic              fetch;

    assign wr_ptr_bin     = PW'(gray2bin(PtrMaxW'(wr_ptr_gray_sync), PW));
    // Full-width compare: equal low bits with differing MSB means full, not empty.
    assign ram_empty      = (rd_ptr_bin_q == wr_ptr_bin);
    assign ram_rd_addr    = rd_ptr_bin_q[AW-1:0];
    assign rd_ptr_bin_inc = rd_ptr_bin_q + PW'(1);

    // A word is fetched whenever one is available and the output register is free or
    // being emptied this cycle, giving back-to-back throughput.
    assign fetch = !ram_empty && ((state_q == IDLE) || m_tready);

    always_comb begin
        state_d       = state_q;
        rd_ptr_bin_d  = rd_ptr_bin_q;
        rd_ptr_gray_d = rd_ptr_gray_q;
        tdata_d       = tdata_q;
        if (fetch) begin
            state_d       = HOLD;
            tdata_d       = ram_rd_data;
            rd_ptr_bin_d  = rd_ptr_bin_inc;
            rd_ptr_gray_d = PW'(bin2gray(PtrMaxW'(rd_ptr_bin_inc), PW));
        end else if ((state_q == HOLD) && m_tready) begin
            // Last word accepted with nothing behind it; data register keeps its value.
            state_d = IDLE;
        end
    end

    always_ff @(posedge rd_clk) begin
        if (!rd_rst_n) begin
            state_q       <= IDLE;
            rd_ptr_bin_q  <= '0;
            rd_ptr_gray_q <= '0;
            tdata_q       <= '0;
        end else begin
            state_q       <= state_d;
            rd_ptr_bin_q  <= rd_ptr_bin_d;
            rd_ptr_gray_q <= rd_ptr_gray_d;
            tdata_q       <= tdata_d;
        end
    end

    assign m_tvalid    = (state_q == HOLD);
    assign m_tdata     = tdata_q;
    assign rd_ptr_gray = rd_ptr_gray_q;

`ifdef FIFO_RD_COUNT_EN
    logic [AW:0] rd_count_q;

    // Modulo subtraction yields 0..DEPTH; sampled from current pointers, so one cycle stale.
    always_ff @(posedge rd_clk) begin
        if (!rd_rst_n) begin
            rd_count_q <= '0;
        end else begin
            rd_count_q <= wr_ptr_bin - rd_ptr_bin_q;
        end
    end

    assign rd_count = rd_count_q;
`endif

endmodule
